// File: rtl/lenet_weight_loader.sv
// Weight-load responder: on a per-layer request, streams that layer's weights then biases
// from weight SRAM into the systolic weight buffer. Define WEIGHT_LOADER_CHECKSUM_EN for checksum_o.
module lenet_weight_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int L1_BASE  = 0,
  parameter int L1_NUM_W = 150,
  parameter int L1_NUM_B = 6,
  parameter int L2_BASE  = 156,
  parameter int L2_NUM_W = 2400,
  parameter int L2_NUM_B = 16
) (
  input  logic              clk_i,
  input  logic              rst_sync_n_i,
  input  logic              req_load_weight_i,
  input  logic [3:0]        layer_id_i,
  output logic              weight_loaded_o,
  output logic              err_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wt_valid_o,
  input  logic              wt_ready_i,
  output logic [DATA_W-1:0] wt_data_o,
  output logic              wt_is_bias_o,
  output logic              wt_last_o,
  output logic [31:0]       checksum_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [3:0]        layer_q, layer_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       total_q, total_d;
  logic [15:0]       num_w_q, num_w_d;
  logic [15:0]       issued_q, issued_d;
  logic [15:0]       delivered_q, delivered_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              err_q, err_d;
  logic              loaded_q, loaded_d;

  logic              fifo_nonempty;
  logic              wt_valid;
  logic              pop;
  logic              push;
  logic              fifo_pop;
  logic              flush;
  logic              id_ok;
  logic [DATA_W-1:0] head;
  logic [2:0]        owned;

  // Head of the skid path: a word returning from SRAM bypasses the FIFO when it is empty.
  always_comb begin
    fifo_nonempty = (fifo_cnt_q != 2'd0);
    wt_valid      = fifo_nonempty | rvalid_q;
    head          = fifo_nonempty ? fifo_q[rd_ptr_q] : mem_rdata_i;
    pop           = wt_valid & wt_ready_i;
    push          = rvalid_q & ~(~fifo_nonempty & pop);
    fifo_pop      = pop & fifo_nonempty;
    // Words held or on their way after this cycle's pop; issuing is gated so this stays <= 2.
    owned         = {1'b0, fifo_cnt_q} + {2'b00, rvalid_q} + {2'b00, rd_en_q} - {2'b00, pop};
    id_ok         = (layer_q == 4'd1) | (layer_q == 4'd2);
  end

  // Next-state, read issue and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    rd_addr_d   = rd_addr_q;
    total_d     = total_q;
    num_w_d     = num_w_q;
    issued_d    = issued_q;
    delivered_d = pop ? (delivered_q + 16'd1) : delivered_q;
    rd_en_d     = 1'b0;
    addr_d      = {ADDR_W{1'b0}};
    err_d       = 1'b0;
    loaded_d    = 1'b0;
    rvalid_d    = rd_en_q;
    flush       = 1'b0;
    fifo_d      = fifo_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
    if (push) begin
      fifo_d[wr_ptr_q] = mem_rdata_i;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d         = wr_ptr_q;
    end
    rd_ptr_d = fifo_pop ? ~rd_ptr_q : rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (req_load_weight_i) begin
          layer_d = layer_id_i;
          err_d   = ~((layer_id_i == 4'd1) | (layer_id_i == 4'd2));
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (!req_load_weight_i) begin
          // An unknown id already flagged err_o on entry, so only a valid load reports the drop.
          err_d   = id_ok;
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (id_ok) begin
          if (layer_q == 4'd1) begin
            addr_d    = ADDR_W'(L1_BASE);
            total_d   = 16'(L1_NUM_W + L1_NUM_B);
            num_w_d   = 16'(L1_NUM_W);
          end else begin
            addr_d    = ADDR_W'(L2_BASE);
            total_d   = 16'(L2_NUM_W + L2_NUM_B);
            num_w_d   = 16'(L2_NUM_W);
          end
          rd_en_d     = 1'b1;
          rd_addr_d   = addr_d + ADDR_ONE;
          issued_d    = 16'd1;
          delivered_d = 16'd0;
          state_d     = S_STREAM;
        end else begin
          loaded_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_STREAM, S_DRAIN: begin
        if (!req_load_weight_i) begin
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (pop && (delivered_q == total_q - 16'd1)) begin
          loaded_d = 1'b1;
          state_d  = S_DONE;
        end else if ((state_q == S_STREAM) && (issued_q != total_q) && (owned < 3'd2)) begin
          rd_en_d   = 1'b1;
          addr_d    = rd_addr_q;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          issued_d  = issued_q + 16'd1;
          state_d   = (issued_d == total_q) ? S_DRAIN : S_STREAM;
        end else begin
          state_d   = (issued_q == total_q) ? S_DRAIN : state_q;
        end
      end
      S_DONE: begin
        if (req_load_weight_i) begin
          loaded_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          loaded_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        flush   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      rd_en_d    = 1'b0;
      addr_d     = {ADDR_W{1'b0}};
      rvalid_d   = 1'b0;
      fifo_cnt_d = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end else begin
      fifo_cnt_d = fifo_cnt_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      state_q     <= S_IDLE;
      layer_q     <= 4'd0;
      rd_addr_q   <= {ADDR_W{1'b0}};
      total_q     <= 16'd0;
      num_w_q     <= 16'd0;
      issued_q    <= 16'd0;
      delivered_q <= 16'd0;
      rd_en_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      rvalid_q    <= 1'b0;
      fifo_q      <= '{default: {DATA_W{1'b0}}};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      err_q       <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      rd_addr_q   <= rd_addr_d;
      total_q     <= total_d;
      num_w_q     <= num_w_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      rvalid_q    <= rvalid_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      err_q       <= err_d;
      loaded_q    <= loaded_d;
    end
  end

  assign weight_loaded_o = loaded_q;
  assign err_o           = err_q;
  assign mem_rd_en_o     = rd_en_q;
  assign mem_addr_o      = addr_q;
  assign wt_valid_o      = wt_valid;
  assign wt_data_o       = wt_valid ? head : {DATA_W{1'b0}};
  assign wt_is_bias_o    = wt_valid & (delivered_q >= num_w_q);
  assign wt_last_o       = wt_valid & (delivered_q == total_q - 16'd1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Region checksum: cleared at lookup, sums every word the buffer accepts.
  always_comb begin
    if (state_q == S_LOOKUP) begin
      csum_d = 32'd0;
    end else if (pop) begin
      csum_d = csum_q + 32'(head);
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      csum_q <= 32'd0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_o = (state_q == S_DONE) ? csum_q : 32'd0;
`else
  assign checksum_o = 32'd0;
`endif

endmodule

// File: tb/tb_lenet_weight_loader.sv
// Directed bench for lenet_weight_loader: layer streams with and without backpressure,
// bad layer id, mid-load drop, mid-stream reset and back-to-back handshake.
module tb_lenet_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [3:0]  layer_id;
  logic        loaded;
  logic        err;
  logic        rd_en;
  logic [15:0] addr;
  logic [31:0] rdata = 32'd0;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        is_bias;
  logic        last;
  logic [31:0] csum;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam logic [31:0] CS_L1 = 32'd12090;
  localparam logic [31:0] CS_L2 = 32'd3294216;
`else
  localparam logic [31:0] CS_L1 = 32'd0;
  localparam logic [31:0] CS_L2 = 32'd0;
`endif

  lenet_weight_loader dut (
    .clk_i             (clk),
    .rst_sync_n_i      (rst_n),
    .req_load_weight_i (req),
    .layer_id_i        (layer_id),
    .weight_loaded_o   (loaded),
    .err_o             (err),
    .mem_rd_en_o       (rd_en),
    .mem_addr_o        (addr),
    .mem_rdata_i       (rdata),
    .wt_valid_o        (valid),
    .wt_ready_i        (ready),
    .wt_data_o         (data),
    .wt_is_bias_o      (is_bias),
    .wt_last_o         (last),
    .checksum_o        (csum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight SRAM model: word at address a holds a; garbage when no read was issued.
  always @(posedge clk) rdata <= rd_en ? {16'd0, addr} : 32'hBAD0_BAD0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_stream(input int n, input int base, input int nw, input bit tog,
                            input int stop_at, output int got, output int last_cyc,
                            output int bad, output int first_rd, output int first_valid,
                            output int n_rd);
    bit          held;
    logic [31:0] hd;
    logic        hb;
    logic        hl;
    int          budget;
    got = 0; last_cyc = -1; bad = 0; first_rd = -1; first_valid = -1; n_rd = 0;
    held = 1'b0; hd = 32'd0; hb = 1'b0; hl = 1'b0; budget = 0;
    while (got < stop_at && budget < 8000) begin
      step();
      budget++;
      ready = tog ? ((budget % 2) == 1) : 1'b1;
      #1;
      if (rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (held && (!valid || data !== hd || is_bias !== hb || last !== hl)) bad++;
      held = 1'b0;
      if (valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (ready) begin
          if (data !== 32'(base + got) || is_bias !== (got >= nw) || last !== (got == n - 1)) bad++;
          got++;
          last_cyc = cyc;
        end else begin
          held = 1'b1; hd = data; hb = is_bias; hl = last;
        end
      end
    end
  endtask

  initial begin
    int n0, got, last_c, bad, frd, fv, nrd;
    rst_n = 1'b0; req = 1'b0; layer_id = 4'd0; ready = 1'b0;
    repeat (2) step();
    check_eq("rst_loaded", {31'd0, loaded}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_csum", csum, 32'd0);
    rst_n = 1'b1; ready = 1'b1;
    step();

    // Layer 1, no backpressure
    layer_id = 4'd1; req = 1'b1; n0 = cyc;
    run_stream(156, 0, 150, 1'b0, 156, got, last_c, bad, frd, fv, nrd);
    check_eq("l1_words", got, 156);
    check_eq("l1_word_errs", bad, 0);
    check_eq("l1_first_rd", frd - n0, 2);
    check_eq("l1_first_valid", fv - n0, 3);
    check_eq("l1_reads", nrd, 156);
    check_eq("l1_last_cycle", last_c - n0, 158);
    ready = 1'b1;
    step();
    check_eq("l1_loaded", {31'd0, loaded}, 32'd1);
    check_eq("l1_csum", csum, CS_L1);

    // Back-to-back: drop right after loaded, re-raise the next cycle
    req = 1'b0;
    step();
    check_eq("b2b_loaded_fall", {31'd0, loaded}, 32'd0);
    check_eq("b2b_csum_idle", csum, 32'd0);
    req = 1'b1; layer_id = 4'd1; n0 = cyc;
    run_stream(156, 0, 150, 1'b0, 156, got, last_c, bad, frd, fv, nrd);
    check_eq("b2b_word_errs", bad, 0);
    check_eq("b2b_first_rd", frd - n0, 2);
    check_eq("b2b_last_cycle", last_c - n0, 158);
    ready = 1'b1;
    step();
    check_eq("b2b_loaded", {31'd0, loaded}, 32'd1);
    req = 1'b0;
    step();

    // Layer 2 with ready toggling 1010...
    req = 1'b1; layer_id = 4'd2;
    run_stream(2416, 156, 2400, 1'b1, 2416, got, last_c, bad, frd, fv, nrd);
    check_eq("l2_words", got, 2416);
    check_eq("l2_word_errs", bad, 0);
    check_eq("l2_reads", nrd, 2416);
    ready = 1'b1;
    step();
    check_eq("l2_loaded", {31'd0, loaded}, 32'd1);
    check_eq("l2_csum", csum, CS_L2);
    req = 1'b0;
    step();

    // Unknown layer id
    layer_id = 4'd7; req = 1'b1;
    step();
    check_eq("bad_err_n1", {31'd0, err}, 32'd1);
    check_eq("bad_loaded_n1", {31'd0, loaded}, 32'd0);
    check_eq("bad_rd_n1", {31'd0, rd_en}, 32'd0);
    step();
    check_eq("bad_err_n2", {31'd0, err}, 32'd0);
    check_eq("bad_loaded_n2", {31'd0, loaded}, 32'd1);
    check_eq("bad_rd_n2", {31'd0, rd_en}, 32'd0);
    check_eq("bad_valid_n2", {31'd0, valid}, 32'd0);
    req = 1'b0;
    step();
    check_eq("bad_loaded_fall", {31'd0, loaded}, 32'd0);

    // Request dropped after 40 words of layer 1, then a clean layer-2 load
    layer_id = 4'd1; req = 1'b1;
    run_stream(156, 0, 150, 1'b0, 40, got, last_c, bad, frd, fv, nrd);
    check_eq("drop_words", got, 40);
    check_eq("drop_word_errs", bad, 0);
    req = 1'b0;
    step();
    check_eq("drop_err", {31'd0, err}, 32'd1);
    check_eq("drop_valid", {31'd0, valid}, 32'd0);
    check_eq("drop_loaded", {31'd0, loaded}, 32'd0);
    step();
    check_eq("drop_err_fall", {31'd0, err}, 32'd0);
    check_eq("drop_loaded_late", {31'd0, loaded}, 32'd0);
    req = 1'b1; layer_id = 4'd2;
    run_stream(2416, 156, 2400, 1'b0, 2416, got, last_c, bad, frd, fv, nrd);
    check_eq("redo_words", got, 2416);
    check_eq("redo_word_errs", bad, 0);
    ready = 1'b1;
    step();
    check_eq("redo_loaded", {31'd0, loaded}, 32'd1);
    check_eq("redo_csum", csum, CS_L2);
    req = 1'b0;
    step();

    // Reset pulse mid-stream, then restart layer 1
    layer_id = 4'd1; req = 1'b1;
    run_stream(156, 0, 150, 1'b0, 20, got, last_c, bad, frd, fv, nrd);
    check_eq("rst2_pre_words", got, 20);
    rst_n = 1'b0; req = 1'b0;
    step();
    check_eq("rst2_outputs",
             {19'd0, loaded, err, rd_en, valid, is_bias, last, |addr, |data, |csum, 4'd0}, 32'd0);
    rst_n = 1'b1; req = 1'b1; layer_id = 4'd1; n0 = cyc;
    run_stream(156, 0, 150, 1'b0, 156, got, last_c, bad, frd, fv, nrd);
    check_eq("rst2_word_errs", bad, 0);
    check_eq("rst2_words", got, 156);
    check_eq("rst2_first_valid", fv - n0, 3);
    check_eq("rst2_last_cycle", last_c - n0, 158);
    ready = 1'b1;
    step();
    check_eq("rst2_loaded", {31'd0, loaded}, 32'd1);
    req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at cycle %0d, expected to end before 50000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lenet_weight_loader.md
Name: lenet_weight_loader

Overview:
Responder side of the controller's weight-load handshake. It accepts a per-layer load request with a layer id and looks up that layer's weight/bias region. It streams the region from the weight memory into the systolic weight buffer under valid/ready backpressure, then acknowledges with weight_loaded_o until the request drops. It sits between the LeNet-5 controller, the weight SRAM, and the systolic wrapper's weight port.

Parameters:
DATA_W, 32, width of one weight/bias word
ADDR_W, 16, weight memory address width
L1_BASE, 0, first word address of layer-1 region
L1_NUM_W, 150, layer-1 weight words (6 filters x 1 ch x 5x5)
L1_NUM_B, 6, layer-1 bias words
L2_BASE, 156, first word address of layer-2 region
L2_NUM_W, 2400, layer-2 weight words (16 x 6 x 5x5)
L2_NUM_B, 16, layer-2 bias words

Ports:
clk_i  in  1  clock
rst_sync_n_i  in  1  reset, synchronous, active-low
req_load_weight_i  in  1  load request level from controller
layer_id_i  in  4  layer to load; sampled when request accepted
weight_loaded_o  out  1  load complete; held until request deasserts
err_o  out  1  one-cycle pulse: bad layer id or request dropped mid-load
mem_rd_en_o  out  1  weight memory read strobe
mem_addr_o  out  ADDR_W  read address
mem_rdata_i  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en_o
wt_valid_o  out  1  word valid toward systolic weight buffer
wt_ready_i  in  1  buffer accepts word
wt_data_o  out  DATA_W  word
wt_is_bias_o  out  1  word is a bias (after all weights of region)
wt_last_o  out  1  final word of region
checksum_o  out  32  region checksum (optional feature)

Behaviour:
- Reset: state IDLE. All outputs 0. Skid FIFO and counters are cleared. Reset mid-transfer abandons the transfer silently, with no err_o.
- FSM states: IDLE, LOOKUP, STREAM, DRAIN, DONE.
- IDLE: if req_load_weight_i=1, latch layer_id_i and go to LOOKUP.
- LOOKUP, 1 cycle:
  - id 1 selects L1_*; id 2 selects L2_*. Load rd_addr=BASE, total=NUM_W+NUM_B, issued=0, delivered=0. Go to STREAM.
  - Any other id: pulse err_o, go to DONE with no transfer, so the controller never hangs.
- STREAM:
  - Issue a read (mem_rd_en_o=1, mem_addr_o=rd_addr, rd_addr++, issued++) when issued<total and fifo_count+inflight<2.
  - Returned data enters a 2-entry skid FIFO. The FIFO head drives wt_data_o/wt_valid_o.
  - Transfer happens when wt_valid_o & wt_ready_i; then delivered++.
  - When issued==total, go to DRAIN.
- DRAIN: keep presenting FIFO contents. When the final word is accepted (delivered reaches total), go to DONE.
- Output word tagging: wt_is_bias_o=1 iff delivered>=NUM_W for the word at the head. wt_last_o=1 iff delivered==total-1.
- wt_data_o, wt_is_bias_o, and wt_last_o stay stable while wt_valid_o=1 and wt_ready_i=0.
- DONE: weight_loaded_o=1. When req_load_weight_i=0, go to IDLE; weight_loaded_o drops the same cycle state leaves DONE.
- Request dropped while in LOOKUP/STREAM/DRAIN: pulse err_o, flush the FIFO, discard any in-flight read, go to IDLE. weight_loaded_o is never asserted for that request.
- Timing, with N = first cycle req is sampled high in IDLE:
  - LOOKUP at N+1; first mem_rd_en_o at N+2; first wt_valid_o at N+3.
  - With wt_ready_i held 1: one word per cycle.
  - Final accept at cycle L gives weight_loaded_o=1 at L+1.
- Simultaneous FIFO push and pop in one cycle: count is unchanged. The FIFO never overflows, because issuing is credit-gated.
- Counters are 16-bit. total is at most 65535 by construction.

Optional Feature:
Macro WEIGHT_LOADER_CHECKSUM_EN.
- Defined: a 32-bit accumulator clears in LOOKUP and adds each accepted word, mod 2^32. checksum_o holds the final sum while in DONE and is 0 otherwise.
- Undefined: the accumulator is not built and checksum_o is tied to 0.

Test Plan:
- Layer 1, wt_ready_i=1, memory word k = k: 156 words 0..155 in order; wt_is_bias_o high for words 150..155; wt_last_o on 155; weight_loaded_o at L+1, where L = N+158. With macro defined, checksum_o = 12090.
- Layer 2, wt_ready_i toggling 1010...: 2416 words from address 156 in order, none lost or duplicated; bias flag on final 16; data stable whenever stalled.
- layer_id_i=7: err_o pulses at N+1; weight_loaded_o=1 at N+2; no mem_rd_en_o or wt_valid_o.
- Request dropped at word 40 of layer 1: err_o pulse; wt_valid_o=0 within 1 cycle; weight_loaded_o stays 0. A new request for layer 2 then completes normally.
- rst_sync_n_i low for 1 cycle mid-stream: all outputs 0 next cycle; FSM in IDLE; a following layer-1 request restarts from address 0.
- Back-to-back handshake: drop req in the cycle after weight_loaded_o=1, then re-raise the next cycle; weight_loaded_o falls, and the new load starts from IDLE.
